// File: rtl/mux_share_arbiter_if.sv
//------------------------------------------------------------------------------
// mux_share_arbiter_if : requester/arbiter signal bundle for the shared 2:1 mux
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mux_share_arbiter_if #(
   parameter int WIDTH = 1
);
   logic             req0;
   logic             req1;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic             gnt0;
   logic             gnt1;
   logic             sel;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;

   modport master (
      output req0, req1, d0, d1,
      input  gnt0, gnt1, sel, dout, dout_valid
   );

   modport slave (
      input  req0, req1, d0, d1,
      output gnt0, gnt1, sel, dout, dout_valid
   );
endinterface

`default_nettype wire

// File: rtl/mux_share_arbiter.sv
//------------------------------------------------------------------------------
// mux_share_arbiter : two-requester round-robin owner of a 2:1 mux select,
//                     with registered output and a per-grant beat cap
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_share_arbiter #(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   mux_share_arbiter_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);
   localparam logic [3:0] HOLD_SAT   = 4'hF;

   logic [1:0]       state_q, state_d;
   logic             prio_q, prio_d;
   logic             sel_q, sel_d;
   logic [3:0]       hold_cnt_q, hold_cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             xfer;

   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      sel_d        = sel_q;
      hold_cnt_d   = hold_cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;

      xfer = ((state_q == OWN0) && bus.req0) || ((state_q == OWN1) && bus.req1);

      case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1)
               state_d = prio_q ? OWN1 : OWN0;
            else if (bus.req0)
               state_d = OWN0;
            else if (bus.req1)
               state_d = OWN1;
         end
         OWN0: begin
            if (!bus.req0)
               state_d = bus.req1 ? OWN1 : IDLE;
            else if (bus.req1 && (hold_cnt_q == HOLD_LIMIT))
               state_d = OWN1;
         end
         OWN1: begin
            if (!bus.req1)
               state_d = bus.req0 ? OWN0 : IDLE;
            else if (bus.req0 && (hold_cnt_q == HOLD_LIMIT))
               state_d = OWN0;
         end
         default: state_d = IDLE;
      endcase

      // sel already points at the owner, so it doubles as the data select
      if (xfer) begin
         dout_d       = sel_q ? bus.d1 : bus.d0;
         dout_valid_d = 1'b1;
      end

      if (state_d != state_q) begin
         if (state_q == OWN0) prio_d = 1'b1;
         if (state_q == OWN1) prio_d = 1'b0;
         if (state_d == OWN0) begin
            sel_d      = 1'b0;
            hold_cnt_d = 4'd0;
         end
         if (state_d == OWN1) begin
            sel_d      = 1'b1;
            hold_cnt_d = 4'd0;
         end
      end else if (xfer && (hold_cnt_q != HOLD_SAT)) begin
         hold_cnt_d = hold_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         sel_q        <= 1'b0;
         hold_cnt_q   <= 4'd0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         sel_q        <= sel_d;
         hold_cnt_q   <= hold_cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign bus.gnt0       = (state_q == OWN0);
   assign bus.gnt1       = (state_q == OWN1);
   assign bus.sel        = sel_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;

endmodule

`default_nettype wire

// File: doc/mux_share_arbiter.md
# mux_share_arbiter

Two-requester round-robin arbiter that owns the select line of the shared 2:1 mux datapath. It grants the mux to one requester at a time and drives `sel` to route that requester's data. It registers the muxed result with a valid flag and caps how many consecutive beats a requester may hold the mux while the other waits. It sits directly in front of the mux cell and replaces hard-wired select control.

## Interface
- `WIDTH`, 1: data width of each mux input and of `dout`.
- `MAX_HOLD`, 4: maximum consecutive transferred beats per grant under contention; legal range 1..15.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `req0`  in  1  requester 0 wants the mux; level, held while data is offered.
- `req1`  in  1  requester 1 wants the mux.
- `d0`  in  WIDTH  requester 0 data (mux input I0).
- `d1`  in  WIDTH  requester 1 data (mux input I1).
- `gnt0`  out  1  requester 0 owns the mux this cycle.
- `gnt1`  out  1  requester 1 owns the mux this cycle.
- `sel`  out  1  mux select: 0 routes `d0`, 1 routes `d1`; holds the last owner while idle.
- `dout`  out  WIDTH  registered mux output.
- `dout_valid`  out  1  `dout` carries a transferred beat.

## Operation
- States: IDLE, OWN0, OWN1. `gnt0` = (state==OWN0), `gnt1` = (state==OWN1), decoded from the state register only. `gnt0` and `gnt1` are never both 1.
- Internal registers:
  - `prio` is the tie-break winner; 0 favours requester 0.
  - `hold_cnt` is 4 bits.
- Transfer: a beat occurs in a cycle where the state is OWNx and `reqx`=1.
- IDLE:
  - req0&req1: go to OWN(prio).
  - Only reqx: go to OWNx.
  - Neither: stay in IDLE.
- OWNx (y is the other requester):
  - `reqx`=0 and `reqy`=1: go to OWNy.
  - `reqx`=0 and `reqy`=0: go to IDLE.
  - `reqx`=1, `reqy`=1 and `hold_cnt`==MAX_HOLD-1: go to OWNy (limit reached).
  - Otherwise stay in OWNx.
- `hold_cnt`:
  - Cleared to 0 on entry to any OWN state.
  - Increments on each transfer while the state is unchanged.
  - Saturates at 15 when there is no contention.
- On every exit from OWNx, `prio` <= y.
- `sel` <= 0 on entering OWN0 and 1 on entering OWN1. It is unchanged otherwise.
- Datapath:
  - On a transfer: `dout` <= (sel ? d1 : d0), `dout_valid` <= 1.
  - Otherwise: `dout_valid` <= 0 and `dout` holds.
- Reset (rst_n=0 at an edge):
  - state IDLE.
  - `gnt0`=`gnt1`=0, `sel`=0, `dout`=0, `dout_valid`=0.
  - `prio`=0, `hold_cnt`=0.
  - Reset applies mid-grant as well. No beat is transferred in the reset cycle.

## Timing
- Request to grant: 1 cycle. `reqx` sampled high in IDLE gives `gntx`=1 after the next edge.
- Grant to data: 1 cycle. `dout`/`dout_valid` reflect the beat sampled at the previous edge.
- Total request-to-`dout_valid` latency from IDLE: 2 cycles.
- Handover:
  - There is no idle gap when ownership passes directly OWNx to OWNy.
  - `sel` and the grants change on the same edge.
- Contention:
  - Exactly MAX_HOLD beats per owner, then strict alternation.
  - With both requesters held high, `gnt0` is 1 for MAX_HOLD cycles, then `gnt1` for MAX_HOLD cycles, repeating.
- MAX_HOLD=1 under contention: the grant alternates every cycle.
- If the owner drops its request on the same edge the limit is reached, the result is the same: move to OWNy.
- Requester contract: `reqx` deasserting in an OWNx cycle means no beat in that cycle. The arbiter never drops a beat it has sampled.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with req0=req1=1, d0=1, d1=0 -> all outputs 0 throughout. First edge with rst_n=1 -> `gnt0`=1 on the following cycle (prio=0).
- Single requester: req0=1 for 3 cycles, d0 = 1,0,1 -> `gnt0` high 3 cycles starting 1 cycle after req0. `dout_valid` high 3 cycles, 1 cycle later still, with `dout` = 1,0,1. Returns to IDLE with `sel`=0.
- Contention, MAX_HOLD=4: req0=req1=1 continuously from IDLE after reset -> `gnt0` for 4 cycles, `gnt1` for 4, `gnt0` for 4. `sel` = 0,0,0,0,1,1,1,1,0... `dout` follows d0/d1 one cycle later with `dout_valid` constantly 1.
- Early release: in OWN0 with hold_cnt=1, drop req0 while req1=1 -> `gnt1`=1 and `sel`=1 the next cycle, with no IDLE cycle between. After both release, a simultaneous req0&req1 -> requester 0 wins (prio=0 after leaving OWN1).
- Tie-break memory: req1 alone served 2 beats, then IDLE, then req0=req1=1 together -> `gnt0` wins. Repeat after a req0-only burst -> `gnt1` wins.
- Reset mid-grant: pulse rst_n=0 for 1 cycle during OWN1 at hold_cnt=2 -> next cycle all outputs 0 and state IDLE. With both requests held, `gnt0`=1 one cycle after rst_n returns high.
